// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Result write-back stage sitting directly in front of the register cells.
//   Each of NUM_SOURCES functional units owns a one-deep holding entry. One
//   held entry per cycle is picked round-robin and broadcast on the shared
//   data bus. A one-hot strobe tells the destination register cell to load
//   the data and clear its write-reserve bit. Every write-back output is
//   registered, so there is no combinational path from a source to wb_*.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous reset, active-low
//   src_valid    in   [NUM_SOURCES]                 source i offers a result
//   src_ready    out  [NUM_SOURCES]                 source i entry can accept
//   src_data     in   [NUM_SOURCES*OPERAND_WIDTH]   result i at [i*W +: W]
//   src_dest     in   [NUM_SOURCES*REG_ADDR_WIDTH]  destination of result i
//   wb_valid     out  a write-back is broadcast this cycle
//   wb_dest      out  [REG_ADDR_WIDTH]  destination of the broadcast
//   wb_data      out  [OPERAND_WIDTH]   data bus to every cell
//   wb_en        out  [NUM_REGS]        one-hot per-register load strobe
//   wb_dest_err  out  sticky flag: an out-of-range destination was dropped
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int NUM_SOURCES    = 4,
  parameter int OPERAND_WIDTH  = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SOURCES-1:0]                src_valid,
  output logic [NUM_SOURCES-1:0]                src_ready,
  input  logic [NUM_SOURCES*OPERAND_WIDTH-1:0]  src_data,
  input  logic [NUM_SOURCES*REG_ADDR_WIDTH-1:0] src_dest,
  output logic                                  wb_valid,
  output logic [REG_ADDR_WIDTH-1:0]             wb_dest,
  output logic [OPERAND_WIDTH-1:0]              wb_data,
  output logic [NUM_REGS-1:0]                   wb_en,
  output logic                                  wb_dest_err
);

  localparam int PTR_W = $clog2(NUM_SOURCES);
  // NUM_REGS fits in one bit more than the address, so the range check
  // needs no wider arithmetic.
  localparam logic [REG_ADDR_WIDTH:0] NUM_REGS_LIM = (REG_ADDR_WIDTH+1)'(NUM_REGS);

  logic [NUM_SOURCES-1:0]    r_held;
  logic [PTR_W-1:0]          r_rr_ptr;
  logic [OPERAND_WIDTH-1:0]  r_data_q [NUM_SOURCES];
  logic [REG_ADDR_WIDTH-1:0] r_dest_q [NUM_SOURCES];

  logic [NUM_SOURCES-1:0]    w_grant;
  logic [NUM_SOURCES-1:0]    w_accept;
  logic                      w_grant_any;
  logic [PTR_W-1:0]          w_grant_idx;
  logic [PTR_W-1:0]          w_scan_ptr;
  logic [PTR_W-1:0]          w_rr_next;
  int                        w_scan_idx;
  logic [REG_ADDR_WIDTH-1:0] w_sel_dest;
  logic [OPERAND_WIDTH-1:0]  w_sel_data;
  logic                      w_dest_ok;
  logic [NUM_REGS-1:0]       w_sel_en;

  // Round-robin pick: first held entry at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    w_scan_idx  = 0;
    w_scan_ptr  = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NUM_SOURCES) w_scan_idx = w_scan_idx - NUM_SOURCES;
      w_scan_ptr = PTR_W'(w_scan_idx);
      if (!w_grant_any && r_held[w_scan_ptr]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan_ptr;
      end
    end
    if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
  end

  // Explicit wrap keeps non-power-of-two source counts correct.
  assign w_rr_next = (w_grant_idx == PTR_W'(NUM_SOURCES - 1)) ? '0 : w_grant_idx + 1'b1;

  // An entry being drained this cycle can refill on the same edge, which
  // gives a lone source one result per cycle.
  assign src_ready = rst ? (~r_held | w_grant) : '0;
  assign w_accept  = src_valid & src_ready;

  assign w_sel_dest = r_dest_q[w_grant_idx];
  assign w_sel_data = r_data_q[w_grant_idx];
  assign w_dest_ok  = ({1'b0, w_sel_dest} < NUM_REGS_LIM);

  always_comb begin
    w_sel_en = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_sel_en[r] = w_dest_ok && (w_sel_dest == REG_ADDR_WIDTH'(r));
    end
  end

  // Holding entries: payload carries no reset, held[] qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_accept[i]) begin
        r_data_q[i] <= src_data[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        r_dest_q[i] <= src_dest[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      end
    end
  end

  // Control state and registered write-back outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held      <= '0;
      r_rr_ptr    <= '0;
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
      wb_data     <= '0;
      wb_en       <= '0;
      wb_dest_err <= 1'b0;
    end else begin
      // A new accept wins over a grant, so grant+accept keeps the entry full.
      r_held <= w_accept | (r_held & ~w_grant);
      if (w_grant_any) begin
        r_rr_ptr <= w_rr_next;
        wb_valid <= 1'b1;
        wb_dest  <= w_sel_dest;
        wb_data  <= w_sel_data;
        wb_en    <= w_sel_en;
        if (!w_dest_ok) wb_dest_err <= 1'b1;
      end else begin
        wb_valid <= 1'b0;
        wb_en    <= '0;
      end
    end
  end

endmodule
